usb_token_req_arbiter: RTL and testbench

Parametrised N-requester token arbiter between USB host-side engines and the single token generator. Examples of requesters are the enumerator, transaction engine and keyboard poller.
- Replaces purely combinational priority muxing with a registered grant and a one-cycle token_start pulse.
- Holds the grant until the generator reports completion.
- Starvation counters promote long-waiting low-priority requesters over fixed priority.

---
 rtl/usb_token_arb_pkg.sv | 25 ++
 rtl/usb_arb_prio_pick.sv | 36 +++
 rtl/usb_token_req_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_usb_token_req_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_token_arb_pkg.sv
// Shared types and constants for the USB token request arbiter.
package usb_token_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } arb_state_e;

  // Token PID-type encodings carried on req_type / token_type
  localparam logic [1:0] OUT   = 2'b00;
  localparam logic [1:0] IN    = 2'b01;
  localparam logic [1:0] SETUP = 2'b10;
  localparam logic [1:0] SOF   = 2'b11;

  // Width of a requester index; never narrower than one bit
  function automatic int grant_id_width(input int num_req);
    if (num_req > 1) begin
      return $clog2(num_req);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/usb_arb_prio_pick.sv
// Combinational requester picker. Starved requesters (a subset of the
// eligible ones) take precedence; within the chosen set the lowest index wins.
module usb_arb_prio_pick
  import usb_token_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = grant_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [NUM_REQ-1:0] starved,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [NUM_REQ-1:0] cand_s;

  assign cand_s = (|starved) ? starved : elig;
  assign any    = |cand_s;

  // Lowest set bit of the candidate vector, as one-hot and as an index
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_s[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = ID_W'(i);
      end else begin
        onehot = onehot;
      end
    end
  end

endmodule

// File: rtl/usb_token_req_arbiter.sv
// N-requester token arbiter in front of the single USB token generator.
// Registered grant, one-cycle token_start / req_ready pulses, grant held until
// tok_done, and starvation counters that promote long-waiting requesters.
// Optional build macro USB_TOKEN_ARB_TIMEOUT_EN adds a completion watchdog
// that aborts a grant after TIMEOUT_CYCLES and pulses timeout_err.
module usb_token_req_arbiter
  import usb_token_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TYPE_W         = 2,
  parameter int ADDR_W         = 7,
  parameter int ENDP_W         = 4,
  parameter int STARVE_LIMIT   = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_active,
  input  logic [NUM_REQ*TYPE_W-1:0]     req_type,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*ENDP_W-1:0]     req_endp,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tok_busy,
  input  logic                          tok_done,
  output logic                          token_start,
  output logic [TYPE_W-1:0]             token_type,
  output logic [ADDR_W-1:0]             token_addr,
  output logic [ENDP_W-1:0]             token_endp,
  output logic                          grant_valid,
  output logic [grant_id_width(NUM_REQ)-1:0] grant_id,
  output logic                          timeout_err
);

  localparam int ID_W  = grant_id_width(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_r, state_nxt_s;
  logic [NUM_REQ-1:0]  elig_s, starved_s, pick_onehot_s;
  logic [ID_W-1:0]     pick_idx_s;
  logic                pick_any_s, issue_s;
  logic [CNT_W-1:0]    starve_cnt_r [NUM_REQ];

  logic [TYPE_W-1:0]   sel_type_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [ENDP_W-1:0]   sel_endp_s;

  logic                token_start_r, token_start_nxt_s;
  logic [NUM_REQ-1:0]  req_ready_r, req_ready_nxt_s;
  logic [TYPE_W-1:0]   token_type_r, token_type_nxt_s;
  logic [ADDR_W-1:0]   token_addr_r, token_addr_nxt_s;
  logic [ENDP_W-1:0]   token_endp_r, token_endp_nxt_s;
  logic                grant_valid_r, grant_valid_nxt_s;
  logic [ID_W-1:0]     grant_id_r, grant_id_nxt_s;

`ifdef USB_TOKEN_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]     wd_r, wd_nxt_s;
  logic                timeout_err_r, timeout_err_nxt_s;
`else
  logic                unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
`endif

  assign elig_s  = req_valid & req_active;
  assign issue_s = (state_r == IDLE) && pick_any_s && !tok_busy;

  // Flag eligible requesters whose wait counter has saturated
  always_comb begin
    starved_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starved_s[i] = elig_s[i] && (starve_cnt_r[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  usb_arb_prio_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .elig    (elig_s),
    .starved (starved_s),
    .onehot  (pick_onehot_s),
    .idx     (pick_idx_s),
    .any     (pick_any_s)
  );

  // Route the picked requester's token fields
  always_comb begin
    sel_type_s = '0;
    sel_addr_s = '0;
    sel_endp_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot_s[i]) begin
        sel_type_s = req_type[i*TYPE_W +: TYPE_W];
        sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
        sel_endp_s = req_endp[i*ENDP_W +: ENDP_W];
      end else begin
        sel_type_s = sel_type_s;
      end
    end
  end

  // Next-state and next-output logic for the grant FSM
  always_comb begin
    state_nxt_s       = state_r;
    token_start_nxt_s = 1'b0;
    req_ready_nxt_s   = '0;
    token_type_nxt_s  = token_type_r;
    token_addr_nxt_s  = token_addr_r;
    token_endp_nxt_s  = token_endp_r;
    grant_valid_nxt_s = grant_valid_r;
    grant_id_nxt_s    = grant_id_r;
`ifdef USB_TOKEN_ARB_TIMEOUT_EN
    wd_nxt_s          = '0;
    timeout_err_nxt_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          state_nxt_s       = WAIT_DONE;
          token_start_nxt_s = 1'b1;
          req_ready_nxt_s   = pick_onehot_s;
          token_type_nxt_s  = sel_type_s;
          token_addr_nxt_s  = sel_addr_s;
          token_endp_nxt_s  = sel_endp_s;
          grant_valid_nxt_s = 1'b1;
          grant_id_nxt_s    = pick_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tok_done) begin
          state_nxt_s       = IDLE;
          grant_valid_nxt_s = 1'b0;
`ifdef USB_TOKEN_ARB_TIMEOUT_EN
        end else if (wd_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt_s       = IDLE;
          grant_valid_nxt_s = 1'b0;
          timeout_err_nxt_s = 1'b1;
        end else begin
          state_nxt_s = WAIT_DONE;
          wd_nxt_s    = wd_r + 1'b1;
        end
`else
        end else begin
          state_nxt_s = WAIT_DONE;
        end
`endif
      end
      default: begin
        state_nxt_s       = IDLE;
        grant_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      token_start_r <= 1'b0;
      req_ready_r   <= '0;
      token_type_r  <= '0;
      token_addr_r  <= '0;
      token_endp_r  <= '0;
      grant_valid_r <= 1'b0;
      grant_id_r    <= '0;
`ifdef USB_TOKEN_ARB_TIMEOUT_EN
      wd_r          <= '0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      token_start_r <= token_start_nxt_s;
      req_ready_r   <= req_ready_nxt_s;
      token_type_r  <= token_type_nxt_s;
      token_addr_r  <= token_addr_nxt_s;
      token_endp_r  <= token_endp_nxt_s;
      grant_valid_r <= grant_valid_nxt_s;
      grant_id_r    <= grant_id_nxt_s;
`ifdef USB_TOKEN_ARB_TIMEOUT_EN
      wd_r          <= wd_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
`endif
    end
  end

  // Starvation counters: count waiting cycles of eligible, non-granted
  // requesters; the current grantee (including one that times out) stays at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        starve_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!elig_s[i] || (issue_s && pick_onehot_s[i]) ||
            (grant_valid_r && (grant_id_r == ID_W'(i)))) begin
          starve_cnt_r[i] <= '0;
        end else if (starve_cnt_r[i] != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt_r[i] <= starve_cnt_r[i] + 1'b1;
        end else begin
          starve_cnt_r[i] <= starve_cnt_r[i];
        end
      end
    end
  end

  assign token_start = token_start_r;
  assign req_ready   = req_ready_r;
  assign token_type  = token_type_r;
  assign token_addr  = token_addr_r;
  assign token_endp  = token_endp_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
`ifdef USB_TOKEN_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_token_req_arbiter.sv
// Directed self-checking bench for usb_token_req_arbiter (3 requesters,
// STARVE_LIMIT=4, TIMEOUT_CYCLES=16). Timeout scenario runs when
// USB_TOKEN_ARB_TIMEOUT_EN is defined.
module tb_usb_token_req_arbiter;
  import usb_token_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_active;
  logic [5:0]  req_type;
  logic [20:0] req_addr;
  logic [11:0] req_endp;
  logic [2:0]  req_ready;
  logic        tok_busy;
  logic        tok_done;
  logic        token_start;
  logic [1:0]  token_type;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int passed = 0;
  int total  = 0;

  usb_token_req_arbiter #(
    .NUM_REQ(3), .TYPE_W(2), .ADDR_W(7), .ENDP_W(4),
    .STARVE_LIMIT(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_active(req_active),
    .req_type(req_type), .req_addr(req_addr), .req_endp(req_endp),
    .req_ready(req_ready), .tok_busy(tok_busy), .tok_done(tok_done),
    .token_start(token_start), .token_type(token_type),
    .token_addr(token_addr), .token_endp(token_endp),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic [1:0] t,
                            input logic [6:0] a, input logic [3:0] e);
    req_type[i*2 +: 2] = t;
    req_addr[i*7 +: 7] = a;
    req_endp[i*4 +: 4] = e;
  endtask

  task automatic wait_start(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      step();
      cycles++;
      if (token_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Pulse tok_done in the cycle after the current one
  task automatic finish_token();
    step();
    tok_done = 1'b1;
    step();
    tok_done = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if ({token_start, req_ready, grant_valid, grant_id} !== 7'd0) $display("FAIL reset_ctrl got %b required 0", {token_start, req_ready, grant_valid, grant_id}); else passed++;
    total++; if ({token_type, token_addr, token_endp} !== 13'd0) $display("FAIL reset_fields got %h required 0", {token_type, token_addr, token_endp}); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout got %b required 0", timeout_err); else passed++;
    step();
    rst_n = 1'b1;
    step();
    total++; if ({token_start, grant_valid} !== 2'b00) $display("FAIL idle_after_reset got %b required 00", {token_start, grant_valid}); else passed++;
    // tok_done while idle must be ignored
    tok_done = 1'b1;
    step();
    tok_done = 1'b0;
    step();
    total++; if ({token_start, grant_valid} !== 2'b00) $display("FAIL done_in_idle got %b required 00", {token_start, grant_valid}); else passed++;
  endtask

  task automatic test_single();
    set_fields(0, SETUP, 7'h11, 4'h7);
    set_fields(1, OUT,   7'h22, 4'h3);
    set_fields(2, IN,    7'h05, 4'h1);
    req_active = 3'b111;
    req_valid  = 3'b100;
    step();
    total++; if (token_start !== 1'b1) $display("FAIL single_start got %b required 1", token_start); else passed++;
    total++; if (req_ready !== 3'b100) $display("FAIL single_ready got %b required 100", req_ready); else passed++;
    total++; if (grant_id !== 2'd2) $display("FAIL single_gid got %0d required 2", grant_id); else passed++;
    total++; if (grant_valid !== 1'b1) $display("FAIL single_gvalid got %b required 1", grant_valid); else passed++;
    total++; if ({token_type, token_addr, token_endp} !== {IN, 7'h05, 4'h1}) $display("FAIL single_fields got %h required %h", {token_type, token_addr, token_endp}, {IN, 7'h05, 4'h1}); else passed++;
    req_valid = 3'b000;
    step();
    total++; if ({token_start, req_ready} !== 4'b0000) $display("FAIL single_pulse_end got %b required 0000", {token_start, req_ready}); else passed++;
    step(); step(); step();
    total++; if ({grant_valid, token_addr} !== {1'b1, 7'h05}) $display("FAIL single_hold got %h required %h", {grant_valid, token_addr}, {1'b1, 7'h05}); else passed++;
    tok_done = 1'b1;
    step();
    tok_done = 1'b0;
    total++; if (grant_valid !== 1'b0) $display("FAIL single_release got %b required 0", grant_valid); else passed++;
    total++; if (grant_id !== 2'd2) $display("FAIL single_gid_hold got %0d required 2", grant_id); else passed++;
  endtask

  task automatic test_simultaneous();
    int  cyc;
    bit  ok;
    logic [6:0] addrs [3];
    addrs[0] = 7'h30; addrs[1] = 7'h31; addrs[2] = 7'h32;
    for (int k = 0; k < 3; k++) set_fields(k, SOF, addrs[k], 4'(k + 8));
    req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_start(10, cyc, ok);
      total++; if (!ok) $display("FAIL sim_start%0d got none required pulse", k); else passed++;
      total++; if (grant_id !== 2'(k)) $display("FAIL sim_gid%0d got %0d required %0d", k, grant_id, k); else passed++;
      total++; if ({req_ready, token_addr} !== {3'(1 << k), addrs[k]}) $display("FAIL sim_sel%0d got %h required %h", k, {req_ready, token_addr}, {3'(1 << k), addrs[k]}); else passed++;
      // one wait step after the tok_done cycle ends means start lands two cycles after tok_done
      if (k > 0) begin
        total++; if (cyc !== 1) $display("FAIL sim_gap%0d got %0d required 1", k, cyc); else passed++;
      end
      req_valid[k] = 1'b0;
      finish_token();
    end
  endtask

  task automatic test_masked();
    int  cyc;
    bit  ok;
    bit  seen0;
    req_active = 3'b110;
    req_valid  = 3'b011;
    wait_start(10, cyc, ok);
    total++; if (!ok || grant_id !== 2'd1) $display("FAIL masked_gid got %0d required 1", grant_id); else passed++;
    total++; if (req_ready !== 3'b010) $display("FAIL masked_ready got %b required 010", req_ready); else passed++;
    req_valid[1] = 1'b0;
    finish_token();
    seen0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (token_start === 1'b1 || req_ready[0] === 1'b1) seen0 = 1'b1;
    end
    total++; if (seen0 !== 1'b0) $display("FAIL masked_never got %b required 0", seen0); else passed++;
    req_valid  = 3'b000;
    req_active = 3'b111;
    step();
  endtask

  task automatic test_starvation();
    int  cyc;
    bit  ok;
    int  exp_ids [3];
    exp_ids[0] = 0; exp_ids[1] = 0; exp_ids[2] = 2;
    req_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      wait_start(10, cyc, ok);
      total++; if (!ok || grant_id !== 2'(exp_ids[k])) $display("FAIL starve_gid%0d got %0d required %0d", k, grant_id, exp_ids[k]); else passed++;
      if (exp_ids[k] == 2) begin
        req_valid[2] = 1'b0;
        total++; if (req_valid[0] !== 1'b1 || req_ready !== 3'b100) $display("FAIL starve_over0 got %b required 100", req_ready); else passed++;
      end
      finish_token();
    end
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_busy_and_reset();
    bit early;
    tok_busy  = 1'b1;
    req_valid = 3'b001;
    early = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (token_start !== 1'b0) early = 1'b1;
    end
    total++; if (early !== 1'b0) $display("FAIL busy_stall got %b required 0", early); else passed++;
    tok_busy = 1'b0;
    step();
    total++; if ({token_start, grant_id} !== 3'b100) $display("FAIL busy_release got %b required 100", {token_start, grant_id}); else passed++;
    req_valid = 3'b000;
    step();
    total++; if (grant_valid !== 1'b1) $display("FAIL busy_waitdone got %b required 1", grant_valid); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({token_start, req_ready, grant_valid, grant_id, timeout_err} !== 8'd0) $display("FAIL async_rst_ctrl got %b required 0", {token_start, req_ready, grant_valid, grant_id, timeout_err}); else passed++;
    total++; if ({token_type, token_addr, token_endp} !== 13'd0) $display("FAIL async_rst_fields got %h required 0", {token_type, token_addr, token_endp}); else passed++;
    step();
    rst_n = 1'b1;
    step();
  endtask

`ifdef USB_TOKEN_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  cyc;
    bit  ok;
    int  n;
    req_valid = 3'b010;
    wait_start(10, cyc, ok);
    total++; if (!ok || grant_id !== 2'd1) $display("FAIL to_grant got %0d required 1", grant_id); else passed++;
    req_valid = 3'b000;
    n = 0;
    while (n < 40 && timeout_err !== 1'b1) begin
      step();
      n++;
    end
    total++; if (n !== 16) $display("FAIL to_latency got %0d required 16", n); else passed++;
    total++; if (grant_valid !== 1'b0) $display("FAIL to_gvalid got %b required 0", grant_valid); else passed++;
    step();
    total++; if (timeout_err !== 1'b0) $display("FAIL to_pulse got %b required 0", timeout_err); else passed++;
    req_valid = 3'b001;
    wait_start(10, cyc, ok);
    total++; if (!ok || grant_id !== 2'd0 || cyc !== 1) $display("FAIL to_recover got id %0d cyc %0d required id 0 cyc 1", grant_id, cyc); else passed++;
    req_valid = 3'b000;
    finish_token();
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    req_valid  = 3'b000;
    req_active = 3'b000;
    req_type   = '0;
    req_addr   = '0;
    req_endp   = '0;
    tok_busy   = 1'b0;
    tok_done   = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_masked();
    test_starvation();
    test_busy_and_reset();
`ifdef USB_TOKEN_ARB_TIMEOUT_EN
    req_active = 3'b111;
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
